// File: rtl/alu_pkg.sv
// alu_pkg: opcode enum and registered flag bundle shared by the pipelined ALU.
package alu_pkg;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_PASS
    } alu_op_e;
    typedef struct packed {
        logic carry;
        logic gt;
        logic eq;
        logic lt;
        logic zero;
    } alu_flags_t;
endpackage

// File: rtl/alu_slice.sv
// alu_slice: WIDTH-bit add/sub/logic slice; SUB adds ~b with the chain carry-in seeded to 1.
module alu_slice import alu_pkg::*; #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_e          op_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] y_o,
    output logic             c_o
);
    logic [WIDTH:0] sum;
    assign sum = {1'b0, a_i} + {1'b0, (op_i == OP_SUB) ? ~b_i : b_i} + {{WIDTH{1'b0}}, c_i};
    assign c_o = sum[WIDTH];
    always_comb begin
        y_o = op_i == OP_AND ? a_i & b_i :
              op_i == OP_OR  ? a_i | b_i :
              op_i == OP_XOR ? a_i ^ b_i : sum[WIDTH-1:0];
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU over N_ALU chained slices with an internal accumulator.
module alu_pipe import alu_pkg::*; #(
    parameter int WIDTH = 4,
    parameter int N_ALU = 4
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*N_ALU-1:0]   a,
    input  logic [WIDTH*N_ALU-1:0]   b,
    input  logic [2:0]               select,
    input  logic                     acc_en,
    input  logic                     acc_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*N_ALU-1:0]   out,
    output logic                     carry_out,
    output logic                     a_greater,
    output logic                     a_equal,
    output logic                     a_less,
    output logic                     zero,
    output logic [WIDTH*N_ALU-1:0]   acc
);
    localparam int DW = WIDTH * N_ALU;
    logic          s1_valid_q, s1_acc_en_q, out_valid_q;
    logic [DW-1:0] s1_a_q, s1_b_q, out_q, acc_q;
    alu_op_e       s1_op_q;
    alu_flags_t    flags_q, flags_d;
    logic          s2_free, s1_move, accept, s1_valid_d, out_valid_d;
    logic [DW-1:0] eff_a, slice_y, res_d, acc_d;
    logic [N_ALU:0] c;
    assign s2_free  = !out_valid_q || out_ready;
    assign s1_move  = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign accept   = in_valid && in_ready;
    assign eff_a    = s1_acc_en_q ? acc_q : s1_a_q;
    assign c[0]     = s1_op_q == OP_SUB;
    for (genvar i = 0; i < N_ALU; i++) begin : g_slice
        alu_slice #(.WIDTH(WIDTH)) u_slice (
            .a_i (eff_a[i*WIDTH +: WIDTH]),
            .b_i (s1_b_q[i*WIDTH +: WIDTH]),
            .op_i(s1_op_q),
            .c_i (c[i]),
            .y_o (slice_y[i*WIDTH +: WIDTH]),
            .c_o (c[i+1])
        );
    end
    always_comb begin
        res_d = s1_op_q == OP_SHL  ? {eff_a[DW-2:0], 1'b0} :
                s1_op_q == OP_SHR  ? {1'b0, eff_a[DW-1:1]} :
                s1_op_q == OP_PASS ? s1_b_q : slice_y;
        flags_d.carry = s1_op_q == OP_ADD ? c[N_ALU] :
                        s1_op_q == OP_SUB ? !c[N_ALU] :
                        s1_op_q == OP_SHL ? eff_a[DW-1] :
                        s1_op_q == OP_SHR ? eff_a[0] : 1'b0;
        flags_d.gt   = eff_a > s1_b_q;
        flags_d.eq   = eff_a == s1_b_q;
        flags_d.lt   = eff_a < s1_b_q;
        flags_d.zero = res_d == '0;
        s1_valid_d   = accept || (s1_valid_q && !s1_move);
        out_valid_d  = s1_move || (out_valid_q && !out_ready);
        // clear wins over a same-edge writeback; the transfer still used the old acc
        acc_d        = acc_clr ? '0 : (s1_move && s1_acc_en_q) ? res_d : acc_q;
    end
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            s1_valid_q  <= 1'b0;
            s1_acc_en_q <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OP_ADD;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            if (accept) begin
                s1_a_q      <= a;
                s1_b_q      <= b;
                s1_op_q     <= alu_op_e'(select);
                s1_acc_en_q <= acc_en;
            end
            if (s1_move) begin
                out_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign carry_out = flags_q.carry;
    assign a_greater = flags_q.gt;
    assign a_equal   = flags_q.eq;
    assign a_less    = flags_q.lt;
    assign zero      = flags_q.zero;
    assign acc       = acc_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against a program-order reference model.
module tb_alu_pipe;
    logic        clk = 1'b0, arst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        acc_en = 1'b0, acc_clr = 1'b0;
    logic [2:0]  select = 3'd0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, carry_out, a_greater, a_equal, a_less, zero;
    logic [15:0] out, acc;
    int          tests = 0, fails = 0, drained = 0, d0;
    logic [15:0] acc_model = '0;
    bit          accepted, pend;
    typedef struct {
        logic [15:0] r;
        logic [4:0]  f;
    } exp_t;
    exp_t q[$];

    alu_pipe #(.WIDTH(4), .N_ALU(4)) dut (
        .clk(clk), .arst(arst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .select(select), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .carry_out(carry_out),
        .a_greater(a_greater), .a_equal(a_equal), .a_less(a_less), .zero(zero), .acc(acc)
    );

    always #5 clk = ~clk;

    // {carry, gt, eq, lt, zero, result} from plain arithmetic on effective A and B
    function automatic logic [20:0] model(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        c = 1'b0;
        s = {1'b0, x} + {1'b0, y};
        case (op)
            3'd0: begin r = s[15:0]; c = s[16]; end
            3'd1: begin r = x - y; c = x < y; end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: begin r = x << 1; c = x[15]; end
            3'd6: begin r = x >> 1; c = x[0]; end
            default: r = y;
        endcase
        return {c, x > y, x == y, x < y, r == 16'd0, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, want);
        end
    endtask

    // one cycle: sample handshakes away from the edge, update scoreboard, advance to next negedge
    task automatic tick();
        logic [20:0] m;
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            drained++;
            chk("unexpected_out", {31'd0, out_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("result", {16'd0, out}, {16'd0, e.r});
                chk("flags", {27'd0, carry_out, a_greater, a_equal, a_less, zero}, {27'd0, e.f});
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            m = model(select, acc_en ? acc_model : a, b);
            q.push_back('{m[15:0], m[20:16]});
            if (acc_en) acc_model = m[15:0];
        end
        if (acc_clr) acc_model = '0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [2:0] op, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] want_r, input logic [4:0] want_f);
        select = op; a = x; b = y; acc_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(tag, {16'd0, out}, {16'd0, want_r});
        chk({tag, "_flags"}, {27'd0, carry_out, a_greater, a_equal, a_less, zero}, {27'd0, want_f});
        tick();
    endtask

    initial begin
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {16'd0, out}, 32'd0);
        chk("rst_flags", {27'd0, carry_out, a_greater, a_equal, a_less, zero}, 32'd0);
        chk("rst_acc", {16'd0, acc}, 32'd0);
        arst = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        directed("add_ovf", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 5'b11001);
        directed("sub_borrow", 3'd1, 16'h0003, 16'h0005, 16'hFFFE, 5'b10010);
        directed("shl", 3'd5, 16'h8000, 16'h0000, 16'h0000, 5'b11001);
        directed("shr", 3'd6, 16'h0001, 16'h0000, 16'h0000, 5'b11001);
        directed("xor", 3'd4, 16'hA5A5, 16'hFFFF, 16'h5A5A, 5'b00010);
        directed("pass_eq", 3'd7, 16'h1234, 16'h1234, 16'h1234, 5'b00100);
        for (int r = 0; r < 2; r++) begin
            acc_clr = 1'b1;
            tick();
            acc_clr = 1'b0;
            select = 3'd0; a = 16'hDEAD; b = 16'h0010; acc_en = 1'b1; out_ready = 1'b1;
            for (int i = 0; i < 6; i++) begin
                in_valid = i < 4;
                acc_clr = (r == 1) && (i == 4);
                if (i >= 2) begin
                    chk("chain_valid", {31'd0, out_valid}, 32'd1);
                    chk("chain_out", {16'd0, out}, 32'(16 * (i - 1)));
                end
                tick();
            end
            acc_clr = 1'b0;
            chk("chain_drained", {31'd0, out_valid}, 32'd0);
            chk("chain_acc", {16'd0, acc}, r == 0 ? 32'h40 : 32'h0);
        end
        acc_en = 1'b0; select = 3'd0; out_ready = 1'b0; d0 = drained;
        a = 16'd1; b = 16'd1; in_valid = 1'b1;
        tick();
        a = 16'd2; b = 16'd2;
        tick();
        a = 16'd3; b = 16'd3;
        chk("bp_full", {31'd0, in_ready}, 32'd0);
        chk("bp_out0", {16'd0, out}, 32'd2);
        tick();
        chk("bp_still_full", {31'd0, in_ready}, 32'd0);
        chk("bp_hold", {16'd0, out}, 32'd2);
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        tick();
        out_ready = 1'b1;
        tick();
        chk("bp_accept_on_release", {31'd0, accepted}, 32'd1);
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_count", 32'(drained - d0), 32'd3);
        pend = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pend && $urandom_range(3) != 0) begin
                select = 3'($urandom_range(7));
                a = 16'($urandom);
                b = ($urandom_range(7) == 0) ? a : 16'($urandom);
                acc_en = 1'($urandom_range(1));
                in_valid = 1'b1;
                pend = 1'b1;
            end else if (!pend) in_valid = 1'b0;
            out_ready = $urandom_range(3) != 0;
            tick();
            if (accepted) pend = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        chk("rand_drain_empty", 32'(q.size()), 32'd0);
        chk("rand_acc", {16'd0, acc}, {16'd0, acc_model});
        select = 3'd0; a = 16'h0; b = 16'h1234; acc_en = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("pre_rst_acc_nonzero", {31'd0, acc != 16'd0}, 32'd1);
        #2 arst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_acc", {16'd0, acc}, 32'd0);
        chk("midrst_out", {16'd0, out}, 32'd0);
        q.delete();
        acc_model = '0;
        @(negedge clk);
        arst = 1'b1;
        #1;
        chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1; d0 = drained;
        repeat (3) tick();
        chk("no_stale", 32'(drained - d0), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Pipelined, handshaked successor to the combinational multi-slice ALU. It chains `N_ALU` slices of `WIDTH` bits into one `WIDTH*N_ALU`-bit datapath and registers it through two stages with valid/ready flow control. It adds an internal accumulator so operand A can be replaced by the previous result. It sits between the operand sequencer and the result consumer in the verification and datapath top.

## Interface
Parameters:
- `WIDTH`, 4, bits per slice
- `N_ALU`, 4, number of chained slices; `DW = WIDTH*N_ALU` (localparam)

Ports:
- `clk`  in  1  single clock, rising edge
- `arst`  in  1  reset, asynchronous and active-low
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  block accepts a beat this cycle
- `a`, `b`  in  DW  operands, unsigned
- `select`  in  3  opcode
- `acc_en`  in  1  per-beat: use accumulator as A and write the result back to the accumulator
- `acc_clr`  in  1  synchronous accumulator clear, independent of handshake
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts the result
- `out`  out  DW  result
- `carry_out`  out  1  carry, borrow or shifted-out bit
- `a_greater`, `a_equal`, `a_less`  out  1  unsigned compare of effective A against B
- `zero`  out  1  `out == 0`
- `acc`  out  DW  current accumulator value

## Operation
- Opcodes:
  - 0 ADD: carry_out = carry out of MSB.
  - 1 SUB: A−B mod 2^DW; carry_out = borrow, which is 1 when A<B.
  - 2 AND, 3 OR, 4 XOR: carry_out = 0.
  - 5 SHL1: carry_out = A[DW-1].
  - 6 SHR1 (logical): carry_out = A[0].
  - 7 PASS B: carry_out = 0.
- Effective A is `acc` when the beat's `acc_en`=1, otherwise the beat's `a`. Shifts and logic use effective A.
- Compare flags are one-hot and reflect effective A vs B for every opcode.
- Stage S1 holds the captured beat: `a`, `b`, `select`, `acc_en`.
- Stage S2 holds `out`, the flags and `zero`. S2 is computed from S1 and `acc` on the S1→S2 transfer edge.
- `acc` loads the result on the same transfer edge when S1.`acc_en`=1. Back-to-back accumulating beats therefore chain with no hazard and no bubble.
- If `acc_clr`=1 at an edge, `acc` becomes 0, overriding any simultaneous accumulator write. The transfer itself still completes, using the pre-clear `acc`.
- Beats are never dropped or reordered. `out` and the flags hold stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset (`arst`=0, immediate): S1 and S2 valid=0, `out`=0, `carry_out`=0, `a_greater`=0, `a_equal`=0, `a_less`=0, `zero`=0, `acc`=0. `in_ready`=1 once reset is released.
- Reset mid-operation discards all in-flight beats.
- Handshake definitions:
  - `s2_free = !out_valid || out_ready`
  - `s1_move = s1_valid && s2_free`
  - `in_ready = !s1_valid || s2_free`
- `out_ready` reaches `in_ready` through a combinational path only; no path goes from `in_valid` to `in_ready`.
- Latency: a beat accepted at edge k appears with `out_valid`=1 after edge k+1 when no stall occurs.
- Throughput: one beat per cycle.
- Full: both stages valid and `out_ready`=0, so `in_ready`=0.
- Simultaneous accept and drain in the same cycle is legal; occupancy is unchanged.
- `in_valid`=0 while `out_ready`=1 drains the pipeline; `out_valid` falls after the last beat leaves.
- `in_valid` with `in_ready`=0: the source must hold the beat. The block does not capture it.

## Structure
- Package `alu_pkg`: `alu_op_e` enum (ADD…PASS, 3 bits) and `alu_flags_t` struct {carry, gt, eq, lt, zero}.
- Sub-module `alu_slice`: WIDTH-bit add/sub/logic slice with carry in/out. It is instantiated N_ALU times in a ripple chain.
- Shifts and compares are implemented in `alu_pipe` over the full DW word.

## Test plan (WIDTH=4, N_ALU=4, DW=16)
- **Add overflow:** ADD a=0xFFFF, b=0x0001, `out_ready`=1 → two cycles later `out`=0x0000, carry=1, `zero`=1, `a_greater`=1.
- **Subtract with borrow:** SUB a=0x0003, b=0x0005 → `out`=0xFFFE, carry=1, `a_less`=1.
- **Shifts:** SHL a=0x8000 → `out`=0x0000, carry=1. SHR a=0x0001 → `out`=0x0000, carry=1. XOR a=0xA5A5, b=0xFFFF → 0x5A5A, carry=0.
- **Accumulate chain:** pulse `acc_clr`, then four back-to-back ADD beats with `acc_en`=1, b=0x0010 → outputs 0x0010, 0x0020, 0x0030, 0x0040 on consecutive cycles; `acc`=0x0040. Repeating with `acc_clr` on the fourth transfer edge gives `out`=0x0040 and `acc`=0.
- **Backpressure:** hold `out_ready`=0 and offer 3 beats → 2 accepted, then `in_ready`=0. Output stays stable. Release `out_ready` → all 3 results arrive in order, none lost or duplicated.
- **Reset mid-flight:** assert `arst`=0 with 2 beats in flight → `out_valid`=0 and `acc`=0 immediately. After release, `in_ready`=1 and no stale result appears.
